lc3_mem_io: RTL and testbench
=============================

LC3_MEM_IO -- requirements
Module: lc3_mem_io

Interface
REQ-001 One clock; reset is asynchronous and active-high. Clock port is clk, reset port is rstn; asserting rstn high resets the block immediately, independent of clk.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 rstn  in  1  asynchronous reset, active-high.
REQ-004 MIO_EN  in  1  access request from the control unit; held high until R is seen.
REQ-005 R_W  in  1  access direction: 1 = write, 0 = read; sampled with MIO_EN.
REQ-006 MAR  in  16  access address.
REQ-007 MDR  in  16  write data.
REQ-008 R  out  1  access complete; one-cycle pulse.
REQ-009 rdata  out  16  read result, loaded into MDR by the datapath.
REQ-010 mem_req  out  1  external SRAM request.
REQ-011 mem_we  out  1  external SRAM write enable.
REQ-012 mem_addr  out  16  external SRAM address.
REQ-013 mem_wdata  out  16  external SRAM write data.
REQ-014 mem_rdata  in  16  external SRAM read data; valid when mem_ack is high.
REQ-015 mem_ack  in  1  external SRAM completion.
REQ-016 kb_valid  in  1  keyboard character present.
REQ-017 kb_data  in  8  keyboard character.
REQ-018 kb_ready  out  1  block can accept a character; equals ~KBSR[15].
REQ-019 kb_intr  out  1  keyboard interrupt request; equals KBSR[15] & KBSR[14].
REQ-020 disp_valid  out  1  display character pending.
REQ-021 disp_data  out  8  display character; equals DDR[7:0].
REQ-022 disp_ack  in  1  display has consumed the character.
REQ-023 halt  out  1  machine halted; equals ~MCR[15].

Function
REQ-024 Device space is xFE00-xFFFF; all other addresses route to external SRAM.
- KBSR = xFE00, KBDR = xFE02, DSR = xFE04, DDR = xFE06, MCR = xFFFE.
REQ-025 The FSM has three states: IDLE, ACCESS, DONE.
- IDLE: when MIO_EN=1, latch MAR, MDR and R_W, then go to ACCESS.
- ACCESS, device address: perform the register access, then go to DONE on the next edge.
- ACCESS, SRAM address: hold mem_req=1 until mem_ack=1, then go to DONE.
- DONE: R=1 for exactly one cycle, then go to IDLE.
REQ-026 SRAM accesses:
- mem_addr, mem_we and mem_wdata come from the latched values and are stable while mem_req=1.
- On mem_ack during a read, capture mem_rdata into rdata.
- mem_ack seen outside ACCESS is ignored.
REQ-027 Device accesses never assert mem_req.
- Unmapped device addresses read as x0000.
- Writes to unmapped device addresses are ignored.
REQ-028 rdata holds its value until the next read completes; writes leave rdata unchanged.
REQ-029 Latency: R rises 2 cycles after MIO_EN is sampled for a device access, and 1 cycle after mem_ack for an SRAM access.
REQ-030 Keyboard:
- When kb_valid=1 and KBSR[15]=0: capture kb_data into KBDR[7:0] (KBDR[15:8]=0) and set KBSR[15].
- A completed KBDR read clears KBSR[15] in the DONE cycle.
- Writing KBSR updates only bit 14; KBDR is read-only.
REQ-031 Display:
- A DDR write when DSR[15]=1 loads DDR[7:0], clears DSR[15] and sets disp_valid.
- disp_ack while disp_valid=1 clears disp_valid and sets DSR[15] on the same edge.
- A DDR write when DSR[15]=0 is dropped but still completes with R.
- Writing DSR updates only bit 14.
- Reading DDR returns {8'h00, DDR[7:0]}.
REQ-032 MCR is fully read/write.
REQ-033 Status register read format: KBSR and DSR read as {bit15, bit14, 14'b0}.
REQ-034 If MIO_EN=1 in IDLE in the cycle right after DONE, a new access starts; no idle gap is required.

Reset
REQ-035 While rstn=1:
- FSM is in IDLE; R=0, rdata=x0000.
- mem_req=0, mem_we=0, mem_addr=x0000, mem_wdata=x0000.
- KBSR=x0000, KBDR=x0000, DSR=x8000, DDR=x0000, MCR=x8000.
- disp_valid=0, halt=0.
REQ-036 Reset asserted mid-access abandons the access: no R pulse and no register update; mem_req drops immediately.

Verification
REQ-037 SRAM read at x3000 with mem_ack 3 cycles after mem_req, mem_rdata=x1234 -> rdata=x1234, R pulses for one cycle the cycle after mem_ack.
REQ-038 SRAM write at x4000 with MDR=xBEEF -> mem_we=1, mem_wdata=xBEEF, mem_addr=x4000 while mem_req=1; rdata unchanged.
REQ-039 kb_valid with kb_data=x41, then read xFE00, then read xFE02 -> KBSR read = x8000, KBDR read = x0041, KBSR[15]=0 after the read, kb_ready=1.
REQ-040 Write xFE06=x0048 -> disp_valid=1, disp_data=x48, DSR=x0000.
- A second write of x0049 before disp_ack is dropped: disp_data stays x48.
- disp_ack -> DSR=x8000.
REQ-041 Write xFFFE=x0000 -> halt=1; no mem_req at any point.
REQ-042 rstn pulsed during an SRAM wait -> mem_req=0 immediately, no R pulse, all registers at their reset values.

Source files
------------

// File: rtl/lc3_mem_io_if.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_io_if
// Purpose  : Control-unit <-> memory/IO access handshake bundle.
// Revision : 1.0
// ============================================================================
interface lc3_mem_io_if;
    logic        MIO_EN;
    logic        R_W;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic        R;
    logic [15:0] rdata;

    modport master (output MIO_EN, output R_W, output MAR, output MDR,
                    input  R,      input  rdata);
    modport slave  (input  MIO_EN, input  R_W, input  MAR, input  MDR,
                    output R,      output rdata);
endinterface
`default_nettype wire

// File: rtl/lc3_mem_io.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_io
// Purpose  : LC-3 memory/IO controller: routes xFE00-xFFFF to device
//            registers (keyboard, display, MCR) and all else to external SRAM.
// Revision : 1.0
// ============================================================================
module lc3_mem_io (
    input  logic         clk,
    input  logic         rstn,
    lc3_mem_io_if.slave  cpu,
    output logic         mem_req,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    output logic [15:0]  mem_wdata,
    input  logic [15:0]  mem_rdata,
    input  logic         mem_ack,
    input  logic         kb_valid,
    input  logic [7:0]   kb_data,
    output logic         kb_ready,
    output logic         kb_intr,
    output logic         disp_valid,
    output logic [7:0]   disp_data,
    input  logic         disp_ack,
    output logic         halt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [15:0] c_addr_kbsr = 16'hFE00;
    localparam logic [15:0] c_addr_kbdr = 16'hFE02;
    localparam logic [15:0] c_addr_dsr  = 16'hFE04;
    localparam logic [15:0] c_addr_ddr  = 16'hFE06;
    localparam logic [15:0] c_addr_mcr  = 16'hFFFE;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_kb_full;
    logic        r_kb_ie;
    logic [7:0]  r_kbdr;
    logic        r_ds_ready;
    logic        r_ds_ie;
    logic [7:0]  r_ddr;
    logic        r_disp_valid;
    logic [15:0] r_mcr;

    logic        w_is_dev;
    logic        w_dev_access;
    logic        w_dev_wr;
    logic        w_dev_rd;
    logic        w_access_done;
    logic        w_R;
    logic        w_mem_req;
    logic [15:0] w_dev_rdata;

    // Device space is xFE00-xFFFF: the top seven address bits are all ones.
    assign w_is_dev      = (r_addr[15:9] == 7'h7F);
    assign w_dev_access  = (r_state == S_ACCESS) && w_is_dev;
    assign w_dev_wr      = w_dev_access && r_we;
    assign w_dev_rd      = w_dev_access && !r_we;
    assign w_access_done = (r_state == S_ACCESS) && (w_is_dev || mem_ack);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_R          = 1'b0;
        w_mem_req    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu.MIO_EN) begin
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_is_dev) begin
                    w_next_state = S_DONE;
                end else begin
                    w_mem_req = 1'b1;
                    if (mem_ack) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_R          = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_dev_rdata = 16'h0000;
        case (r_addr)
            c_addr_kbsr: w_dev_rdata = {r_kb_full, r_kb_ie, 14'b0};
            c_addr_kbdr: w_dev_rdata = {8'h00, r_kbdr};
            c_addr_dsr:  w_dev_rdata = {r_ds_ready, r_ds_ie, 14'b0};
            c_addr_ddr:  w_dev_rdata = {8'h00, r_ddr};
            c_addr_mcr:  w_dev_rdata = r_mcr;
            default:     w_dev_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_we         <= 1'b0;
            r_addr       <= 16'h0000;
            r_wdata      <= 16'h0000;
            r_rdata      <= 16'h0000;
            r_kb_full    <= 1'b0;
            r_kb_ie      <= 1'b0;
            r_kbdr       <= 8'h00;
            r_ds_ready   <= 1'b1;
            r_ds_ie      <= 1'b0;
            r_ddr        <= 8'h00;
            r_disp_valid <= 1'b0;
            r_mcr        <= 16'h8000;
        end else begin
            if ((r_state == S_IDLE) && cpu.MIO_EN) begin
                r_addr  <= cpu.MAR;
                r_wdata <= cpu.MDR;
                r_we    <= cpu.R_W;
            end

            if (w_access_done && !r_we) begin
                r_rdata <= w_is_dev ? w_dev_rdata : mem_rdata;
            end

            // A KBDR read empties the buffer as the access enters DONE.
            if (w_dev_rd && (r_addr == c_addr_kbdr)) begin
                r_kb_full <= 1'b0;
            end else if (kb_valid && !r_kb_full) begin
                r_kbdr    <= kb_data;
                r_kb_full <= 1'b1;
            end

            if (disp_ack && r_disp_valid) begin
                r_disp_valid <= 1'b0;
                r_ds_ready   <= 1'b1;
            end

            if (w_dev_wr) begin
                case (r_addr)
                    c_addr_kbsr: r_kb_ie <= r_wdata[14];
                    c_addr_dsr:  r_ds_ie <= r_wdata[14];
                    c_addr_ddr: begin
                        // Ready is only set while nothing is pending, so this
                        // never collides with the disp_ack update above.
                        if (r_ds_ready) begin
                            r_ddr        <= r_wdata[7:0];
                            r_ds_ready   <= 1'b0;
                            r_disp_valid <= 1'b1;
                        end
                    end
                    c_addr_mcr:  r_mcr <= r_wdata;
                    default: ;
                endcase
            end
        end
    end

    assign cpu.R      = w_R;
    assign cpu.rdata  = r_rdata;
    assign mem_req    = w_mem_req;
    assign mem_we     = w_mem_req & r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign kb_ready   = ~r_kb_full;
    assign kb_intr    = r_kb_full & r_kb_ie;
    assign disp_valid = r_disp_valid;
    assign disp_data  = r_ddr;
    assign halt       = ~r_mcr[15];

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_mem_io
// Purpose  : Directed + randomized bench for lc3_mem_io against a
//            transaction-level model of the device registers and SRAM.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_lc3_mem_io;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        kb_valid, kb_ready, kb_intr;
    logic [7:0]  kb_data;
    logic        disp_valid, disp_ack, halt;
    logic [7:0]  disp_data;

    int n_assert = 0;
    int n_fail   = 0;

    lc3_mem_io_if bus ();

    lc3_mem_io dut (
        .clk        (clk),
        .rstn       (rstn),
        .cpu        (bus),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .kb_ready   (kb_ready),
        .kb_intr    (kb_intr),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ack   (disp_ack),
        .halt       (halt)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register contents and external memory.
    bit          m_kfull, m_kie, m_dready, m_die, m_dvalid;
    logic [7:0]  m_kbdr, m_ddr;
    logic [15:0] m_mcr, m_rdata;
    logic [15:0] sram [logic [15:0]];
    logic [15:0] dev_addrs [7] = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06,
                                   16'hFFFE, 16'hFE08, 16'hFF00};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sram_val(input logic [15:0] a);
        return sram.exists(a) ? sram[a] : (a ^ 16'h5A3C);
    endfunction

    task automatic model_reset();
        m_kfull = 0; m_kie = 0; m_dready = 1; m_die = 0; m_dvalid = 0;
        m_kbdr = 8'h00; m_ddr = 8'h00; m_mcr = 16'h8000; m_rdata = 16'h0000;
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a < 16'hFE00) return sram_val(a);
        case (a)
            16'hFE00: return {m_kfull, m_kie, 14'b0};
            16'hFE02: return {8'h00, m_kbdr};
            16'hFE04: return {m_dready, m_die, 14'b0};
            16'hFE06: return {8'h00, m_ddr};
            16'hFFFE: return m_mcr;
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic model_access(input logic we, input logic [15:0] a, input logic [15:0] d);
        if (we) begin
            if (a < 16'hFE00) sram[a] = d;
            else case (a)
                16'hFE00: m_kie = d[14];
                16'hFE04: m_die = d[14];
                16'hFE06: if (m_dready) begin m_ddr = d[7:0]; m_dready = 0; m_dvalid = 1; end
                16'hFFFE: m_mcr = d;
                default: ;
            endcase
        end else begin
            m_rdata = model_read(a);
            if (a == 16'hFE02) m_kfull = 0;
        end
    endtask

    task automatic check_state(input string tag);
        chk ({tag, " rdata"},      bus.rdata, m_rdata);
        chk1({tag, " kb_ready"},   kb_ready,  ~m_kfull);
        chk1({tag, " kb_intr"},    kb_intr,   m_kfull & m_kie);
        chk1({tag, " disp_valid"}, disp_valid, m_dvalid);
        chk ({tag, " disp_data"},  {8'h00, disp_data}, {8'h00, m_ddr});
        chk1({tag, " halt"},       halt,      ~m_mcr[15]);
    endtask

    // One CPU access; also acts as the SRAM responder. Called at a negedge.
    // b2b: previous access held MIO_EN through DONE. hold: keep MIO_EN up at R.
    task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d,
                          input int delay, input bit b2b = 0, input bit hold = 0);
        bit dev, done, unstable;
        int cyc, req_seen;
        dev = (a >= 16'hFE00); done = 0; unstable = 0; cyc = 0; req_seen = 0;
        bus.MIO_EN = 1'b1; bus.R_W = we; bus.MAR = a; bus.MDR = d;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (bus.R === 1'b1) begin
                done = 1;
                mem_ack = 1'b0;
                if (!hold) bus.MIO_EN = 1'b0;
                chk1($sformatf("mem_req low at R %h", a), mem_req, 1'b0);
            end else if (mem_req === 1'b1) begin
                req_seen++;
                if (mem_addr !== a || mem_we !== we || mem_wdata !== d) unstable = 1;
                if (req_seen > delay) begin
                    mem_ack = 1'b1; mem_rdata = we ? 16'($urandom) : sram_val(a);
                end else begin
                    mem_ack = 1'b0; mem_rdata = 16'($urandom);
                end
            end else begin
                mem_ack = 1'b0;
            end
        end
        bus.MIO_EN = hold ? bus.MIO_EN : 1'b0;
        mem_ack = 1'b0;
        chk1($sformatf("R seen %h", a), done, 1'b1);
        chki($sformatf("latency %h", a), cyc, (dev ? 2 : delay + 2) + (b2b ? 1 : 0));
        chki($sformatf("mem_req cycles %h", a), req_seen, dev ? 0 : delay + 1);
        chk1($sformatf("sram bus stable %h", a), unstable, 1'b0);
        if (!hold) begin
            @(negedge clk);
            chk1($sformatf("R one cycle %h", a), bus.R, 1'b0);
        end
        model_access(we, a, d);
    endtask

    task automatic kb_pulse(input logic [7:0] c);
        kb_valid = 1'b1; kb_data = c;
        @(negedge clk);
        kb_valid = 1'b0;
        if (!m_kfull) begin m_kbdr = c; m_kfull = 1; end
    endtask

    task automatic ack_pulse();
        disp_ack = 1'b1;
        @(negedge clk);
        disp_ack = 1'b0;
        if (m_dvalid) begin m_dvalid = 0; m_dready = 1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w, op;
        bit          r_seen;
        logic [15:0] a;

        rstn = 1'b1; bus.MIO_EN = 0; bus.R_W = 0; bus.MAR = 0; bus.MDR = 0;
        mem_ack = 0; mem_rdata = 0; kb_valid = 0; kb_data = 0; disp_ack = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_state("reset");
        chk1("reset R", bus.R, 1'b0);
        chk1("reset mem_req", mem_req, 1'b0);
        chk1("reset mem_we", mem_we, 1'b0);
        chk ("reset mem_addr", mem_addr, 16'h0000);
        chk ("reset mem_wdata", mem_wdata, 16'h0000);
        rstn = 1'b0;
        @(negedge clk);

        // SRAM read with a 3-cycle wait, then SRAM write
        sram[16'h3000] = 16'h1234;
        access(0, 16'h3000, 16'h0000, 3);
        chk("sram read x3000", bus.rdata, 16'h1234);
        access(1, 16'h4000, 16'hBEEF, 1);
        chk("rdata after write", bus.rdata, 16'h1234);

        // Keyboard
        kb_pulse(8'h41);
        chk1("kb_ready after char", kb_ready, 1'b0);
        access(0, 16'hFE00, 0, 0);
        chk("KBSR read", bus.rdata, 16'h8000);
        access(0, 16'hFE02, 0, 0);
        chk("KBDR read", bus.rdata, 16'h0041);
        chk1("kb_ready after KBDR read", kb_ready, 1'b1);
        access(1, 16'hFE00, 16'hFFFF, 0);
        access(0, 16'hFE00, 0, 0);
        chk("KBSR only bit14 writable", bus.rdata, 16'h4000);
        kb_pulse(8'h7E);
        chk1("kb_intr", kb_intr, 1'b1);
        access(1, 16'hFE02, 16'h1111, 0);
        access(0, 16'hFE02, 0, 0);
        chk("KBDR read-only", bus.rdata, 16'h007E);

        // Display
        access(1, 16'hFE06, 16'h0048, 0);
        chk1("disp_valid", disp_valid, 1'b1);
        chk ("disp_data", {8'h00, disp_data}, 16'h0048);
        access(0, 16'hFE04, 0, 0);
        chk("DSR busy", bus.rdata, 16'h0000);
        access(1, 16'hFE06, 16'h0049, 0);
        chk("dropped DDR write", {8'h00, disp_data}, 16'h0048);
        ack_pulse();
        chk1("disp_valid after ack", disp_valid, 1'b0);
        access(0, 16'hFE04, 0, 0);
        chk("DSR ready", bus.rdata, 16'h8000);
        access(0, 16'hFE06, 0, 0);
        chk("DDR read", bus.rdata, 16'h0048);

        // MCR, unmapped device addresses
        access(1, 16'hFFFE, 16'h0000, 0);
        chk1("halt", halt, 1'b1);
        access(1, 16'hFE10, 16'h1234, 0);
        access(0, 16'hFE10, 0, 0);
        chk("unmapped read", bus.rdata, 16'h0000);
        check_state("directed");

        // Back-to-back accesses with no idle gap
        access(0, 16'hFE04, 0, 0, 0, 1);
        access(0, 16'hFFFE, 0, 0, 1, 0);
        chk("b2b MCR read", bus.rdata, 16'h0000);
        access(1, 16'h3008, 16'hCAFE, 2, 0, 1);
        access(0, 16'h3008, 0, 1, 1, 0);
        chk("b2b sram read", bus.rdata, 16'hCAFE);

        // Stray mem_ack while idle
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ack = 1'b0;
        chk1("stray ack no R", bus.R, 1'b0);
        check_state("stray ack");

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: access(1, 16'h3000 + 16'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 4));
                1: access(0, 16'h3000 + 16'($urandom_range(0, 7)), 0, $urandom_range(0, 4));
                2: access(0, dev_addrs[$urandom_range(0, 6)], 0, 0);
                3: access(1, dev_addrs[$urandom_range(0, 6)], 16'($urandom), 0);
                4: kb_pulse(8'($urandom));
                default: ack_pulse();
            endcase
            check_state($sformatf("rand%0d op%0d", i, op));
        end

        // Reset during an SRAM wait
        a = 16'h3100;
        bus.MIO_EN = 1; bus.R_W = 0; bus.MAR = a; bus.MDR = 0; mem_ack = 0;
        w = 0;
        while (mem_req !== 1'b1 && w < 10) begin @(negedge clk); w++; end
        chk1("mem_req before reset", mem_req, 1'b1);
        @(negedge clk);
        #2 rstn = 1'b1;
        #1;
        chk1("mem_req drops on reset", mem_req, 1'b0);
        chk1("no R on reset", bus.R, 1'b0);
        model_reset();
        @(negedge clk);
        check_state("mid-access reset");
        chk ("reset mem_addr 2", mem_addr, 16'h0000);
        chk1("reset mem_we 2", mem_we, 1'b0);
        bus.MIO_EN = 0;
        @(negedge clk);
        rstn = 1'b0;
        r_seen = 0;
        repeat (4) begin @(negedge clk); if (bus.R === 1'b1) r_seen = 1; end
        chk1("no R after abandoned access", r_seen, 1'b0);
        access(0, 16'hFE00, 0, 0); chk("post-reset KBSR", bus.rdata, 16'h0000);
        access(0, 16'hFE04, 0, 0); chk("post-reset DSR",  bus.rdata, 16'h8000);
        access(0, 16'hFE06, 0, 0); chk("post-reset DDR",  bus.rdata, 16'h0000);
        access(0, 16'hFFFE, 0, 0); chk("post-reset MCR",  bus.rdata, 16'h8000);
        access(0, 16'hFE02, 0, 0); chk("post-reset KBDR", bus.rdata, 16'h0000);
        check_state("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
